demux_1to4_reg: RTL and testbench

DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

---
 rtl/demux_1to4_reg.sv | 63 ++++++
 tb/tb_demux_1to4_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-lane valid flags and a frame-complete pulse.
// Optional auto-sequencing lane pointer enabled by defining DEMUX_AUTO_SEQ_EN.
module demux_1to4_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic [1:0] select,
  input  logic       load,
  input  logic       clear,
  input  logic       auto_en,
  output logic [3:0] out,
  output logic [3:0] out_valid,
  output logic       frame_done,
  output logic [1:0] ptr
);

  logic [1:0] lane;
  logic [3:0] lane_mask;
  logic [3:0] valid_next;

`ifdef DEMUX_AUTO_SEQ_EN
  logic [1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst || clear)
      ptr_q <= 2'b00;
    else if (load && auto_en)
      ptr_q <= ptr_q + 2'd1;
  end

  assign ptr  = ptr_q;
  assign lane = auto_en ? ptr_q : select;
`else
  logic unused_auto_en;

  assign unused_auto_en = auto_en;
  assign ptr            = 2'b00;
  assign lane           = select;
`endif

  always_comb begin
    lane_mask       = '0;
    lane_mask[lane] = 1'b1;
  end

  assign valid_next = load ? (out_valid | lane_mask) : out_valid;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out        <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        out[lane]       <= in;
        out_valid[lane] <= 1'b1;
      end
      // Pulse only on the not-all-ones -> all-ones transition, so reloads of a full frame stay quiet.
      frame_done <= (out_valid != 4'b1111) && (valid_next == 4'b1111);
    end
  end

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed self-checking bench for demux_1to4_reg; expectations follow DEMUX_AUTO_SEQ_EN.
module tb_demux_1to4_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic [1:0] select;
  logic       load;
  logic       clear;
  logic       auto_en;
  logic [3:0] out;
  logic [3:0] out_valid;
  logic       frame_done;
  logic [1:0] ptr;

  int checks = 0;
  int errors = 0;

`ifdef DEMUX_AUTO_SEQ_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic [10:0] obs;
  assign obs = {out, out_valid, ptr, frame_done};

  demux_1to4_reg dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .select     (select),
    .load       (load),
    .clear      (clear),
    .auto_en    (auto_en),
    .out        (out),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .ptr        (ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; load = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  // obs layout: {out[3:0], out_valid[3:0], ptr[1:0], frame_done}
  task automatic test_reset();
    logic [10:0] exp;
    rst = 1'b1; in = 1'b1; select = 2'd2; load = 1'b1; clear = 1'b0; auto_en = 1'b0;
    tick();
    tick();
    rst = 1'b0; load = 1'b0;
    exp = {4'b0000, 4'b0000, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, exp); end
  endtask

  task automatic test_single_load();
    logic [10:0] exp;
    select = 2'd1; in = 1'b1; load = 1'b1; auto_en = 1'b0;
    tick();
    load = 1'b0;
    exp = {4'b0010, 4'b0010, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_load: got %b expected %b", obs, exp); end
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL hold_no_load: got %b expected %b", obs, exp); end
  endtask

  task automatic test_explicit_frame();
    logic [1:0]  lanes [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    logic        bits  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0]  exp_out [4] = '{4'b1000, 4'b1000, 4'b1001, 4'b1101};
    logic [3:0]  exp_val [4] = '{4'b1000, 4'b1010, 4'b1011, 4'b1111};
    logic [10:0] exp;
    do_clear();
    auto_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      select = lanes[i]; in = bits[i]; load = 1'b1;
      tick();
      exp = {exp_out[i], exp_val[i], 2'd0, (i == 3)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL explicit_frame step %0d: got %b expected %b", i, obs, exp); end
    end
    load = 1'b0;
    tick();
    exp = {4'b1101, 4'b1111, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL frame_done_one_cycle: got %b expected %b", obs, exp); end
    select = 2'd0; in = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    exp = {4'b1100, 4'b1111, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL overwrite_no_repulse: got %b expected %b", obs, exp); end
  endtask

`ifdef DEMUX_AUTO_SEQ_EN
  task automatic test_auto_seq();
    logic        bits    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  exp_out [5] = '{4'b0001, 4'b0011, 4'b0011, 4'b1011, 4'b1010};
    logic [3:0]  exp_val [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
    logic [1:0]  exp_ptr [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [10:0] exp;
    do_clear();
    auto_en = 1'b1; select = 2'd3;
    checks++;
    if (ptr !== 2'd0) begin errors++; $display("FAIL auto_ptr_start: got %0d expected 0", ptr); end
    for (int i = 0; i < 5; i++) begin
      in = bits[i]; load = 1'b1;
      tick();
      exp = {exp_out[i], exp_val[i], exp_ptr[i], (i == 3)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL auto_seq step %0d: got %b expected %b", i, obs, exp); end
    end
    load = 1'b0;
    tick();
    auto_en = 1'b0;
    tick();
    exp = {4'b1010, 4'b1111, 2'd1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL auto_ptr_hold: got %b expected %b", obs, exp); end
    select = 2'd2; in = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    exp = {4'b1110, 4'b1111, 2'd1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL auto_toggle_select: got %b expected %b", obs, exp); end
  endtask
`else
  task automatic test_no_auto();
    logic [10:0] exp;
    do_clear();
    auto_en = 1'b1; select = 2'd2; in = 1'b1; load = 1'b1;
    tick();
    exp = {4'b0100, 4'b0100, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL no_auto_select: got %b expected %b", obs, exp); end
    select = 2'd0; in = 1'b1;
    tick();
    load = 1'b0; auto_en = 1'b0;
    exp = {4'b0101, 4'b0101, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL no_auto_ptr_const: got %b expected %b", obs, exp); end
  endtask
`endif

  task automatic test_clear_with_load();
    logic [10:0] exp;
    do_clear();
    auto_en = 1'b1;
    select = 2'd0; in = 1'b1; load = 1'b1;
    tick();
    select = 2'd1; in = 1'b1;
    tick();
    exp = {4'b0011, 4'b0011, (AUTO ? 2'd2 : 2'd0), 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pre_clear_frame: got %b expected %b", obs, exp); end
    select = 2'd2; in = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    exp = {4'b0000, 4'b0000, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL clear_wins: got %b expected %b", obs, exp); end
    select = 2'd3; in = 1'b1;
    tick();
    load = 1'b0; auto_en = 1'b0;
    exp = AUTO ? {4'b0001, 4'b0001, 2'd1, 1'b0} : {4'b1000, 4'b1000, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL load_after_clear: got %b expected %b", obs, exp); end
  endtask

  task automatic test_rst_mid_frame();
    logic [10:0] exp;
    logic [3:0]  mask;
    do_clear();
    auto_en = 1'b0; in = 1'b1; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      select = 2'(i);
      tick();
    end
    exp = {4'b0111, 4'b0111, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pre_rst_frame: got %b expected %b", obs, exp); end
    select = 2'd3; clear = 1'b1; rst = 1'b1;
    #2;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_not_async: got %b expected %b", obs, exp); end
    tick();
    rst = 1'b0; clear = 1'b0;
    exp = {4'b0000, 4'b0000, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_priority: got %b expected %b", obs, exp); end
    for (int i = 0; i < 4; i++) begin
      select = 2'(i);
      tick();
      mask = 4'((1 << (i + 1)) - 1);
      exp = {mask, mask, 2'd0, (i == 3)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL post_rst_frame step %0d: got %b expected %b", i, obs, exp); end
    end
    load = 1'b0;
    tick();
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL post_rst_pulse_end: got %b expected 0", frame_done); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_explicit_frame();
`ifdef DEMUX_AUTO_SEQ_EN
    test_auto_seq();
`else
    test_no_auto();
`endif
    test_clear_with_load();
    test_rst_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
